// File: rtl/ansi_csi_decoder.sv
// Decodes the ANSI/VT escape subset (CUP 'H', ED 'J', SGR 'm') from a terminal byte stream
// into screen commands; every other byte passes through as a glyph byte.
module ansi_csi_decoder #(
  parameter int unsigned ARG_W        = 8,
  parameter int unsigned HOME_DEFAULT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             cmd_valid,
  output logic [1:0]       cmd_op,
  output logic [ARG_W-1:0] cmd_arg0,
  output logic [ARG_W-1:0] cmd_arg1,
  output logic [1:0]       cmd_nargs,
  output logic             char_valid,
  output logic [7:0]       char_byte,
  output logic             err
);

  localparam int unsigned      ACC_W    = ARG_W + 4;
  localparam logic [ARG_W-1:0] ARG_MAX  = '1;
  localparam logic [ARG_W-1:0] HOME_ARG = ARG_W'(HOME_DEFAULT);

  localparam logic [1:0] S_GROUND = 2'd0;
  localparam logic [1:0] S_ESC    = 2'd1;
  localparam logic [1:0] S_CSI    = 2'd2;

  localparam logic [1:0] OP_GOTO  = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;
  localparam logic [1:0] OP_SGR   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [ARG_W-1:0] arg0_q, arg0_d, arg1_q, arg1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             pres_q, pres_d, ovf_q, ovf_d, unsup_q, unsup_d;
  logic             cmd_valid_q, cmd_valid_d, char_valid_q, char_valid_d, err_q, err_d;
  logic [1:0]       cmd_op_q, cmd_op_d, cmd_nargs_q, cmd_nargs_d;
  logic [ARG_W-1:0] cmd_arg0_q, cmd_arg0_d, cmd_arg1_q, cmd_arg1_d;
  logic [7:0]       char_byte_q, char_byte_d;

  // Decimal accumulation into the currently open parameter, saturating at ARG_MAX
  logic [ARG_W-1:0] cur_arg;
  logic [ACC_W-1:0] acc;
  logic [ARG_W-1:0] acc_sat;
  logic [1:0]       nargs_fin;

  always_comb begin
    cur_arg   = (cnt_q == 2'd0) ? arg0_q : arg1_q;
    acc       = ACC_W'(cur_arg) * ACC_W'(10) + ACC_W'(in_byte[3:0]);
    acc_sat   = (acc > ACC_W'(ARG_MAX)) ? ARG_MAX : acc[ARG_W-1:0];
    nargs_fin = 2'(cnt_q + 2'(pres_q));
  end

  always_comb begin
    state_d      = state_q;
    arg0_d       = arg0_q;
    arg1_d       = arg1_q;
    cnt_d        = cnt_q;
    pres_d       = pres_q;
    ovf_d        = ovf_q;
    unsup_d      = unsup_q;
    cmd_valid_d  = 1'b0;
    char_valid_d = 1'b0;
    err_d        = 1'b0;
    cmd_op_d     = cmd_op_q;
    cmd_arg0_d   = cmd_arg0_q;
    cmd_arg1_d   = cmd_arg1_q;
    cmd_nargs_d  = cmd_nargs_q;
    char_byte_d  = char_byte_q;

    if (in_valid) begin
      case (state_q)
        S_GROUND: begin
          if (in_byte == 8'h1B) begin
            state_d = S_ESC;
          end else if (in_byte != 8'h00) begin
            char_valid_d = 1'b1;
            char_byte_d  = in_byte;
          end
        end
        S_ESC: begin
          if (in_byte == 8'h5B) begin
            state_d = S_CSI;
            arg0_d  = '0;
            arg1_d  = '0;
            cnt_d   = 2'd0;
            pres_d  = 1'b0;
            ovf_d   = 1'b0;
            unsup_d = 1'b0;
          end else if (in_byte == 8'h1B) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = S_GROUND;
          end
        end
        S_CSI: begin
          if (in_byte >= 8'h30 && in_byte <= 8'h39) begin
            // Digits of a third parameter are ignored; overflow is already flagged
            if (cnt_q == 2'd0)      arg0_d = acc_sat;
            else if (cnt_q == 2'd1) arg1_d = acc_sat;
            pres_d = 1'b1;
          end else if (in_byte == 8'h3B) begin
            pres_d = 1'b0;
            if (cnt_q == 2'd0) begin
              cnt_d = 2'd1;
            end else begin
              cnt_d = 2'd2;
              ovf_d = 1'b1;
            end
          end else if ((in_byte >= 8'h3A && in_byte <= 8'h3F) ||
                       (in_byte >= 8'h20 && in_byte <= 8'h2F)) begin
            unsup_d = 1'b1;
          end else if (in_byte == 8'h1B) begin
            err_d   = 1'b1;
            state_d = S_ESC;
          end else if (in_byte < 8'h20 || in_byte > 8'h7E) begin
            err_d   = 1'b1;
            state_d = S_GROUND;
          end else begin
            state_d     = S_GROUND;
            cmd_nargs_d = nargs_fin;
            cmd_arg0_d  = arg0_q;
            cmd_arg1_d  = arg1_q;
            if (ovf_q || unsup_q) begin
              err_d = 1'b1;
            end else begin
              case (in_byte)
                8'h48: begin
                  cmd_valid_d = 1'b1;
                  cmd_op_d    = OP_GOTO;
                  cmd_arg0_d  = (arg0_q == '0) ? HOME_ARG : arg0_q;
                  cmd_arg1_d  = (arg1_q == '0) ? HOME_ARG : arg1_q;
                end
                8'h4A: begin
                  if (nargs_fin == 2'd1 && arg0_q == ARG_W'(2)) begin
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = OP_CLEAR;
                  end else begin
                    err_d = 1'b1;
                  end
                end
                8'h6D: begin
                  cmd_valid_d = 1'b1;
                  cmd_op_d    = OP_SGR;
                end
                default: err_d = 1'b1;
              endcase
            end
          end
        end
        default: state_d = S_GROUND;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_GROUND;
      arg0_q       <= '0;
      arg1_q       <= '0;
      cnt_q        <= 2'd0;
      pres_q       <= 1'b0;
      ovf_q        <= 1'b0;
      unsup_q      <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_op_q     <= 2'd0;
      cmd_arg0_q   <= '0;
      cmd_arg1_q   <= '0;
      cmd_nargs_q  <= 2'd0;
      char_valid_q <= 1'b0;
      char_byte_q  <= 8'h00;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      arg0_q       <= arg0_d;
      arg1_q       <= arg1_d;
      cnt_q        <= cnt_d;
      pres_q       <= pres_d;
      ovf_q        <= ovf_d;
      unsup_q      <= unsup_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_op_q     <= cmd_op_d;
      cmd_arg0_q   <= cmd_arg0_d;
      cmd_arg1_q   <= cmd_arg1_d;
      cmd_nargs_q  <= cmd_nargs_d;
      char_valid_q <= char_valid_d;
      char_byte_q  <= char_byte_d;
      err_q        <= err_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_op     = cmd_op_q;
  assign cmd_arg0   = cmd_arg0_q;
  assign cmd_arg1   = cmd_arg1_q;
  assign cmd_nargs  = cmd_nargs_q;
  assign char_valid = char_valid_q;
  assign char_byte  = char_byte_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ansi_csi_decoder.sv
// Directed bench for ansi_csi_decoder: byte strings in, logged command/glyph/err pulses
// compared against hand-computed expectations.
module tb_ansi_csi_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       cmd_valid, char_valid, err;
  logic [1:0] cmd_op, cmd_nargs;
  logic [7:0] cmd_arg0, cmd_arg1, char_byte;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [1:0] n;
  } cmd_t;

  cmd_t       cmdq[$];
  logic [7:0] charq[$];
  int         errs = 0;
  int         multi = 0;
  int         total = 0;
  int         bad = 0;

  ansi_csi_decoder #(.ARG_W(8), .HOME_DEFAULT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_byte(in_byte),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg0(cmd_arg0), .cmd_arg1(cmd_arg1),
    .cmd_nargs(cmd_nargs), .char_valid(char_valid), .char_byte(char_byte), .err(err)
  );

  always #5 clk = ~clk;

  // Log every output pulse just after the active edge
  always @(posedge clk) begin
    #1;
    if (cmd_valid) cmdq.push_back({cmd_op, cmd_arg0, cmd_arg1, cmd_nargs});
    if (char_valid) charq.push_back(char_byte);
    if (err) errs++;
    if (32'(cmd_valid) + 32'(char_valid) + 32'(err) > 1) multi++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]));
    idle(3);
  endtask

  task automatic clear_log();
    cmdq.delete();
    charq.delete();
    errs = 0;
  endtask

  task automatic chk_cmd(input string tag, input int idx, input logic [1:0] op,
                         input logic [7:0] a0, input logic [7:0] a1, input logic [1:0] n);
    cmd_t c;
    if (idx < cmdq.size()) begin
      c = cmdq[idx];
      chk({tag, "_op"}, 32'(c.op), 32'(op));
      chk({tag, "_a0"}, 32'(c.a0), 32'(a0));
      chk({tag, "_a1"}, 32'(c.a1), 32'(a1));
      chk({tag, "_n"},  32'(c.n),  32'(n));
    end else begin
      chk({tag, "_present"}, 32'(cmdq.size()), 32'(idx + 1));
    end
  endtask

  task automatic chk_char(input string tag, input int idx, input logic [7:0] b);
    if (idx < charq.size()) chk(tag, 32'(charq[idx]), 32'(b));
    else chk({tag, "_present"}, 32'(charq.size()), 32'(idx + 1));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_char_valid", 32'(char_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_op", 32'(cmd_op), 0);
    rst_n = 1'b1;
    idle(2);

    // Goto with explicit latency check on the final byte
    clear_log();
    send_str("\033[12;40");
    send_byte(8'h48);
    @(posedge clk);
    #1;
    chk("t1_lat_valid", 32'(cmd_valid), 1);
    chk("t1_lat_op", 32'(cmd_op), 1);
    idle(3);
    chk("t1_ncmd", 32'(cmdq.size()), 1);
    chk_cmd("t1", 0, 2'd1, 8'd12, 8'd40, 2'd2);
    chk("t1_err", 32'(errs), 0);

    clear_log();
    send_str("\033[2J\033[H");
    chk("t2_ncmd", 32'(cmdq.size()), 2);
    chk_cmd("t2a", 0, 2'd2, 8'd2, 8'd0, 2'd1);
    chk_cmd("t2b", 1, 2'd1, 8'd1, 8'd1, 2'd0);
    chk("t2_chars", 32'(charq.size()), 0);

    clear_log();
    send_str("\033[1;33m<\\\\");
    chk("t3_ncmd", 32'(cmdq.size()), 1);
    chk_cmd("t3", 0, 2'd3, 8'd1, 8'd33, 2'd2);
    chk("t3_nchars", 32'(charq.size()), 3);
    chk_char("t3_c0", 0, 8'h3C);
    chk_char("t3_c1", 1, 8'h5C);
    chk_char("t3_c2", 2, 8'h5C);

    clear_log();
    send_str("\033[999;0H");
    chk_cmd("t4a", 0, 2'd1, 8'd255, 8'd1, 2'd2);
    clear_log();
    send_str("\033[1;2;3m");
    chk("t4b_err", 32'(errs), 1);
    chk("t4b_ncmd", 32'(cmdq.size()), 0);

    clear_log();
    send_str("\033[5XA");
    chk("t5a_err", 32'(errs), 1);
    chk_char("t5a_A", 0, 8'h41);
    clear_log();
    send_str("\033QA");
    chk("t5b_err", 32'(errs), 1);
    chk("t5b_nchars", 32'(charq.size()), 1);
    chk_char("t5b_A", 0, 8'h41);
    clear_log();
    send_str("\033[?25hA");
    chk("t5c_err", 32'(errs), 1);
    chk("t5c_ncmd", 32'(cmdq.size()), 0);
    chk_char("t5c_A", 0, 8'h41);

    // Empty first param still counts; missing goto args default; bare SGR; bad clear
    clear_log();
    send_str("\033[;5H\033[m\033[3J");
    chk_cmd("t7a", 0, 2'd1, 8'd1, 8'd5, 2'd2);
    chk_cmd("t7b", 1, 2'd3, 8'd0, 8'd0, 2'd0);
    chk("t7_ncmd", 32'(cmdq.size()), 2);
    chk("t7_err", 32'(errs), 1);

    // NUL dropped, UTF-8 passes through, ESC ESC errs once then sequence still decodes
    clear_log();
    send_byte(8'h00);
    send_byte(8'hE2);
    send_byte(8'h94);
    send_byte(8'h80);
    send_str("\033\033[7;9H");
    chk("t8_nchars", 32'(charq.size()), 3);
    chk_char("t8_c0", 0, 8'hE2);
    chk_char("t8_c2", 2, 8'h80);
    chk("t8_err", 32'(errs), 1);
    chk_cmd("t8", 0, 2'd1, 8'd7, 8'd9, 2'd2);

    // Reset mid-sequence abandons it
    clear_log();
    send_str("\033[12;");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_err", 32'(err), 0);
    chk("t6_rst_cv", 32'(cmd_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_str("7H");
    chk("t6_ncmd", 32'(cmdq.size()), 0);
    chk("t6_err", 32'(errs), 0);
    chk("t6_nchars", 32'(charq.size()), 2);
    chk_char("t6_c0", 0, 8'h37);
    chk_char("t6_c1", 1, 8'h48);

    chk("onehot", 32'(multi), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
